qsys_led_master_0_packets_to_bytes: RTL and testbench

Transmit-side Avalon-ST packet-to-byte encoder for the JTAG/host master link. It is the inverse of the byte-to-packet path: it takes channel-tagged packet beats and serialises them into a flat byte stream.
- Framing is carried by in-band special characters: 0x7A SOP, 0x7B EOP, 0x7C CHANNEL, 0x7D ESCAPE.
- Any payload or channel byte that collides with a special character is escaped.
- The output feeds the byte-stream transport toward the host.

---
 rtl/qsys_led_st_bytes_pkg.sv | 25 ++
 rtl/qsys_led_st_byte_escape.sv | 13 +
 rtl/qsys_led_master_0_packets_to_bytes.sv | 122 ++++++++++++
 tb/tb_qsys_led_master_0_packets_to_bytes.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/qsys_led_st_bytes_pkg.sv
// Shared framing characters, encoder state enum and the special-byte test
// for the Avalon-ST packet-to-byte encoder.
package qsys_led_st_bytes_pkg;

  localparam logic [7:0] SOP_CHAR  = 8'h7A;
  localparam logic [7:0] EOP_CHAR  = 8'h7B;
  localparam logic [7:0] CHAN_CHAR = 8'h7C;
  localparam logic [7:0] ESC_CHAR  = 8'h7D;
  localparam logic [7:0] ESC_XOR   = 8'h20;

  typedef enum logic [2:0] {
    ST_CHAN,
    ST_CHAN_VAL,
    ST_CHAN_ESC2,
    ST_SOP,
    ST_EOP,
    ST_DATA,
    ST_DATA_ESC2
  } st_e;

  function automatic logic is_special(input logic [7:0] b);
    return (b >= SOP_CHAR) && (b <= ESC_CHAR);
  endfunction

endpackage

// File: rtl/qsys_led_st_byte_escape.sv
// Classifies one byte as a framing character and supplies its escaped form.
module qsys_led_st_byte_escape
  import qsys_led_st_bytes_pkg::*;
(
  input  logic [7:0] raw,
  output logic       special,
  output logic [7:0] escaped_value
);

  assign special       = is_special(raw);
  assign escaped_value = raw ^ ESC_XOR;

endmodule

// File: rtl/qsys_led_master_0_packets_to_bytes.sv
// Serialises channel-tagged Avalon-ST beats into an escaped, in-band framed
// byte stream. Each beat's byte sequence is walked by the FSM below.
//
// state        | meaning
// ST_CHAN      | idle / decide whether a channel header is needed (emits 0x7C)
// ST_CHAN_VAL  | channel byte, or 0x7D if the channel is special
// ST_CHAN_ESC2 | second half of an escaped channel byte
// ST_SOP       | 0x7A start-of-packet marker
// ST_EOP       | 0x7B end-of-packet marker
// ST_DATA      | payload byte, or 0x7D if the payload is special
// ST_DATA_ESC2 | second half of an escaped payload byte
module qsys_led_master_0_packets_to_bytes
  import qsys_led_st_bytes_pkg::*;
#(
  parameter int CHANNEL_WIDTH       = 8,
  parameter bit ALWAYS_SEND_CHANNEL = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic [CHANNEL_WIDTH-1:0] in_channel,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data
);

  st_e                      state, state_nx, eff, next_after;
  logic                     chan_known;
  logic [CHANNEL_WIDTH-1:0] last_chan;
  logic                     need_chan, advance, last_byte, chan_take;
  logic                     ch_special, data_special;
  logic [7:0]               ch_escaped, data_escaped;

  qsys_led_st_byte_escape u_chan_esc (
    .raw           (in_channel),
    .special       (ch_special),
    .escaped_value (ch_escaped)
  );

  qsys_led_st_byte_escape u_data_esc (
    .raw           (in_data),
    .special       (data_special),
    .escaped_value (data_escaped)
  );

  always_comb begin
    need_chan = in_startofpacket &&
                (!chan_known || (in_channel != last_chan) || ALWAYS_SEND_CHANNEL);

    // Skipped states collapse combinationally so they cost no cycle.
    eff = state;
    if (eff == ST_CHAN && !need_chan)       eff = ST_SOP;
    if (eff == ST_SOP  && !in_startofpacket) eff = ST_EOP;
    if (eff == ST_EOP  && !in_endofpacket)   eff = ST_DATA;

    out_valid  = in_valid && !reset;
    advance    = out_valid && out_ready;
    out_data   = in_data;
    next_after = state;
    last_byte  = 1'b0;
    chan_take  = 1'b0;

    case (eff)
      ST_CHAN: begin
        out_data   = CHAN_CHAR;
        next_after = ST_CHAN_VAL;
      end
      ST_CHAN_VAL: begin
        out_data   = ch_special ? ESC_CHAR : in_channel;
        next_after = ch_special ? ST_CHAN_ESC2 : ST_SOP;
        chan_take  = 1'b1;
      end
      ST_CHAN_ESC2: begin
        out_data   = ch_escaped;
        next_after = ST_SOP;
      end
      ST_SOP: begin
        out_data   = SOP_CHAR;
        next_after = ST_EOP;
      end
      ST_EOP: begin
        out_data   = EOP_CHAR;
        next_after = ST_DATA;
      end
      ST_DATA: begin
        out_data   = data_special ? ESC_CHAR : in_data;
        next_after = data_special ? ST_DATA_ESC2 : ST_CHAN;
        last_byte  = !data_special;
      end
      ST_DATA_ESC2: begin
        out_data   = data_escaped;
        next_after = ST_CHAN;
        last_byte  = 1'b1;
      end
      default: begin
        next_after = ST_CHAN;
      end
    endcase

    in_ready = advance && last_byte;
    state_nx = advance ? next_after : state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_CHAN;
      chan_known <= 1'b0;
      last_chan  <= '0;
    end else begin
      state <= state_nx;
      if (advance && chan_take) begin
        last_chan  <= in_channel;
        chan_known <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qsys_led_master_0_packets_to_bytes.sv
// Directed and randomized checks of the packet-to-byte encoder against a
// queue-based model of the framing and escape rules.
module tb_qsys_led_master_0_packets_to_bytes;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] in_channel;
  logic       in_startofpacket;
  logic       in_endofpacket;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;

  int errors = 0;
  int checks = 0;

  bit         m_known;
  logic [7:0] m_last;
  logic [7:0] exp_q[$];
  bit         rdy_pat[$];
  bit         rand_ready = 1'b0;

  qsys_led_master_0_packets_to_bytes dut (
    .clk              (clk),
    .reset            (reset),
    .in_ready         (in_ready),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_channel       (in_channel),
    .in_startofpacket (in_startofpacket),
    .in_endofpacket   (in_endofpacket),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .out_data         (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_enc(input logic [7:0] b);
    if (b >= 8'h7A && b <= 8'h7D) begin
      exp_q.push_back(8'h7D);
      exp_q.push_back(b ^ 8'h20);
    end else begin
      exp_q.push_back(b);
    end
  endfunction

  function automatic void model_beat(input bit sop, input bit eop,
                                     input logic [7:0] ch, input logic [7:0] d);
    exp_q.delete();
    if (sop && (!m_known || ch != m_last)) begin
      exp_q.push_back(8'h7C);
      push_enc(ch);
      m_known = 1'b1;
      m_last  = ch;
    end
    if (sop) exp_q.push_back(8'h7A);
    if (eop) exp_q.push_back(8'h7B);
    push_enc(d);
  endfunction

  function automatic logic next_ready();
    if (rdy_pat.size() > 0) return rdy_pat.pop_front();
    if (rand_ready) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input bit sop, input bit eop,
                           input logic [7:0] ch, input logic [7:0] d);
    int idx;
    int cyc;
    int n;
    idx = 0;
    cyc = 0;
    model_beat(sop, eop, ch, d);
    n = exp_q.size();
    in_valid         = 1'b1;
    in_startofpacket = sop;
    in_endofpacket   = eop;
    in_channel       = ch;
    in_data          = d;
    while (idx < n && cyc < 64) begin
      out_ready = next_ready();
      @(negedge clk);
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_data", 32'(out_data), 32'(exp_q[idx]));
      check("in_ready", 32'(in_ready), 32'(out_ready && (idx == n - 1)));
      if (out_ready) idx++;
      cyc++;
      @(posedge clk);
      #1;
    end
    check("beat_done", 32'(idx), 32'(n));
    in_valid = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    in_valid         = 1'b1;
    in_startofpacket = 1'b1;
    in_endofpacket   = 1'b1;
    in_channel       = 8'h00;
    in_data          = 8'h41;
    out_ready        = 1'b1;
    m_known          = 1'b0;
    m_last           = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // first packet after reset carries a header
    send_beat(1'b1, 1'b1, 8'h00, 8'h41);

    // known channel, escaped middle byte
    send_beat(1'b1, 1'b0, 8'h00, 8'h10);
    send_beat(1'b0, 1'b0, 8'h00, 8'h7B);
    send_beat(1'b0, 1'b1, 8'h00, 8'h22);

    // channel change to a special channel value
    send_beat(1'b1, 1'b1, 8'h7D, 8'h55);

    // backpressure during an escaped data byte: 7A 7B 7D(stall x2) 5D
    rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    send_beat(1'b1, 1'b1, 8'h7D, 8'h7D);

    // reset while the second half of an escaped channel is presented
    in_valid         = 1'b1;
    in_startofpacket = 1'b1;
    in_endofpacket   = 1'b1;
    in_channel       = 8'h7C;
    in_data          = 8'h33;
    out_ready        = 1'b1;
    @(negedge clk);
    check("esc_hdr", 32'(out_data), 32'h7C);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("esc_chan1", 32'(out_data), 32'h7D);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("esc_chan2", 32'(out_data), 32'h5C);
    check("esc_chan2_rdy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    m_known  = 1'b0;
    m_last   = 8'h00;
    @(negedge clk);
    check("post_rst_idle", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    send_beat(1'b1, 1'b1, 8'h00, 8'h44);

    // 256-byte stream, one payload byte per cycle
    for (int i = 0; i < 256; i++)
      send_beat(i == 0, i == 255, 8'h00, 8'(i % 112));

    // randomized packets with random backpressure
    rand_ready = 1'b1;
    for (int p = 0; p < 30; p++) begin
      int len;
      logic [7:0] ch;
      logic [7:0] d;
      len = int'($urandom_range(1, 4));
      case ($urandom_range(0, 5))
        0:       ch = 8'h00;
        1:       ch = 8'h7A;
        2:       ch = 8'h7C;
        3:       ch = 8'h7D;
        4:       ch = 8'h33;
        default: ch = 8'hFF;
      endcase
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 1) != 0) d = 8'(8'h7A + 8'($urandom_range(0, 3)));
        else                           d = 8'($urandom);
        send_beat(b == 0, b == len - 1, ch, d);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
